// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter and command sequencer in front of the SDRAM controller.
// One transaction in flight at a time; stalled transactions are aborted after TIMEOUT cycles.
module sdram_arbiter #(
  parameter int unsigned AW      = 23,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clki,
  input  logic          rst_in,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [15:0]   m0_wdata,
  output logic          m0_done,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [15:0]   m1_wdata,
  output logic          m1_done,
  output logic [31:0]   rdata,
  output logic [1:0]    gnt,
  output logic          err,
  input  logic          err_clr,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_busy,
  input  logic          mem_cack,
  input  logic          mem_ready
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

  state_t        state;
  logic          last;
  logic          we_q;
  logic [CW-1:0] cnt;

  logic pick1_c;
  logic abort_c;

  // Port1 wins when it is the only requester, or on contention when port0 was served last.
  assign pick1_c = m1_req & (~m0_req | ~last);

  // A completion seen in the same cycle as the limit takes precedence over the abort.
  assign abort_c = (((state == ISSUE) & ~mem_cack) | ((state == WAIT_RD) & ~mem_ready))
                   & (cnt == TMO);

  always_ff @(posedge clki or negedge rst_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      last      <= 1'b1;
      we_q      <= 1'b0;
      cnt       <= '0;
      gnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
      m0_done   <= 1'b0;
      m1_done   <= 1'b0;
    end else begin
      m0_done <= 1'b0;
      m1_done <= 1'b0;

      if (err_clr) begin
        err <= 1'b0;
      end else if (abort_c) begin
        err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (!mem_busy && (m0_req || m1_req)) begin
            gnt       <= pick1_c ? 2'b10 : 2'b01;
            last      <= pick1_c;
            mem_addr  <= pick1_c ? m1_addr : m0_addr;
            mem_wdata <= pick1_c ? m1_wdata : m0_wdata;
            we_q      <= pick1_c ? m1_we : m0_we;
            mem_read  <= pick1_c ? ~m1_we : ~m0_we;
            mem_write <= pick1_c ? m1_we : m0_we;
            cnt       <= '0;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          if (mem_cack) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (we_q) begin
              state <= DONE;
            end else if (mem_ready) begin
              rdata <= mem_rdata;
              state <= DONE;
            end else begin
              state <= WAIT_RD;
            end
          end else if (abort_c) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rdata     <= '0;
            state     <= DONE;
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end

        WAIT_RD: begin
          if (mem_ready) begin
            rdata <= mem_rdata;
            state <= DONE;
          end else if (abort_c) begin
            rdata <= '0;
            state <= DONE;
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end

        DONE: begin
          m0_done <= gnt[0];
          m1_done <= gnt[1];
          gnt     <= '0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a transaction-level model.
module tb_sdram_arbiter;

  localparam int AW  = 23;
  localparam int TMO = 16;

  logic          clki;
  logic          rst_in;
  logic          m0_req, m0_we, m0_done;
  logic [AW-1:0] m0_addr;
  logic [15:0]   m0_wdata;
  logic          m1_req, m1_we, m1_done;
  logic [AW-1:0] m1_addr;
  logic [15:0]   m1_wdata;
  logic [31:0]   rdata;
  logic [1:0]    gnt;
  logic          err, err_clr;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_read, mem_write;
  logic [31:0]   mem_rdata;
  logic          mem_busy, mem_cack, mem_ready;

  sdram_arbiter #(.AW(AW), .TIMEOUT(TMO)) dut (
    .clki(clki), .rst_in(rst_in),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_done(m0_done),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_done(m1_done),
    .rdata(rdata), .gnt(gnt), .err(err), .err_clr(err_clr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy), .mem_cack(mem_cack), .mem_ready(mem_ready)
  );

  initial clki = 1'b0;
  always #5 clki = ~clki;

  int checks = 0;
  int errors = 0;

  // Model: one record describing the transaction in flight, if any.
  bit            in_txn, cmd_out, closing, is_wr;
  int            owner, age, last_win;
  logic [AW-1:0] e_addr;
  logic [15:0]   e_wdata;
  logic [31:0]   e_rdata;
  bit            e_err, e_d0, e_d1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    in_txn = 0; cmd_out = 0; closing = 0; is_wr = 0;
    owner = 0; age = 0; last_win = 1;
    e_addr = '0; e_wdata = '0; e_rdata = '0; e_err = 0; e_d0 = 0; e_d1 = 0;
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  function automatic void model_step();
    bit timed_out;
    int w;
    timed_out = 0;
    e_d0 = 0; e_d1 = 0;
    if (!rst_in) begin
      model_reset();
      return;
    end
    if (!in_txn) begin
      if (!mem_busy && (m0_req || m1_req)) begin
        if (m0_req && m1_req) w = (last_win == 0) ? 1 : 0;
        else w = m1_req ? 1 : 0;
        in_txn = 1; owner = w; last_win = w; cmd_out = 1; closing = 0; age = 0;
        is_wr   = (w == 1) ? m1_we : m0_we;
        e_addr  = (w == 1) ? m1_addr : m0_addr;
        e_wdata = (w == 1) ? m1_wdata : m0_wdata;
      end
    end else if (closing) begin
      if (owner == 0) e_d0 = 1; else e_d1 = 1;
      in_txn = 0; closing = 0;
    end else if (cmd_out && mem_cack) begin
      cmd_out = 0;
      if (is_wr) closing = 1;
      else if (mem_ready) begin e_rdata = mem_rdata; closing = 1; end
    end else if (!cmd_out && mem_ready) begin
      e_rdata = mem_rdata; closing = 1;
    end else if (age >= TMO) begin
      cmd_out = 0; e_rdata = '0; closing = 1; timed_out = 1;
    end else begin
      age++;
    end
    if (err_clr) e_err = 0;
    else if (timed_out) e_err = 1;
  endfunction

  task automatic compare_all();
    logic [1:0] eg;
    eg = !in_txn ? 2'b00 : (owner == 0 ? 2'b01 : 2'b10);
    chk("gnt", 32'(gnt), 32'(eg));
    chk("mem_read", 32'(mem_read), 32'(in_txn && cmd_out && !is_wr));
    chk("mem_write", 32'(mem_write), 32'(in_txn && cmd_out && is_wr));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    chk("rdata", rdata, e_rdata);
    chk("err", 32'(err), 32'(e_err));
    chk("m0_done", 32'(m0_done), 32'(e_d0));
    chk("m1_done", 32'(m1_done), 32'(e_d1));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cyc();
    @(posedge clki);
    model_step();
    @(negedge clki);
    compare_all();
  endtask

  task automatic next_grant(output logic [1:0] g);
    logic [1:0] pg;
    pg = gnt;
    g  = 2'b00;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (gnt != 2'b00 && pg == 2'b00) begin
        g = gnt;
        return;
      end
      pg = gnt;
    end
  endtask

  task automatic rand_phase(input int ncyc, input int cack_pct, input int rdy_pct);
    for (int i = 0; i < ncyc; i++) begin
      rst_in    = ($urandom_range(399) == 0) ? 1'b0 : 1'b1;
      mem_busy  = ($urandom_range(99) < 20);
      mem_cack  = ($urandom_range(99) < cack_pct);
      mem_ready = ($urandom_range(99) < rdy_pct);
      mem_rdata = $urandom;
      err_clr   = ($urandom_range(29) == 0);
      if (m0_req && (e_d0 || $urandom_range(59) == 0)) m0_req = 1'b0;
      else if (!m0_req && $urandom_range(3) == 0) begin
        m0_req = 1'b1; m0_we = 1'($urandom_range(1));
        m0_addr = AW'($urandom); m0_wdata = 16'($urandom);
      end
      if (m1_req && (e_d1 || $urandom_range(59) == 0)) m1_req = 1'b0;
      else if (!m1_req && $urandom_range(3) == 0) begin
        m1_req = 1'b1; m1_we = 1'($urandom_range(1));
        m1_addr = AW'($urandom); m1_wdata = 16'($urandom);
      end
      cyc();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [1:0] g;
    int n;
    bit seen;

    rst_in = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    err_clr = 0; mem_rdata = '0; mem_busy = 0; mem_cack = 0; mem_ready = 0;
    model_reset();
    #2 rst_in = 1'b0;
    cyc(); cyc();
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_mem_read", 32'(mem_read), 32'd0);
    rst_in = 1'b1;
    cyc();

    // Contention: port0 first after reset, then strict alternation.
    mem_cack = 1; mem_ready = 1; mem_rdata = 32'h1234_5678;
    m0_req = 1; m1_req = 1; m0_addr = 23'h000010; m1_addr = 23'h000020;
    next_grant(g); chk("t2_first_grant", 32'(g), 32'h1);
    next_grant(g); chk("t2_second_grant", 32'(g), 32'h2);
    m0_req = 0; m1_req = 0;
    repeat (4) cyc();
    m0_req = 1; m1_req = 1;
    next_grant(g); chk("t2_regrant0", 32'(g), 32'h1);
    next_grant(g); chk("t2_alt1", 32'(g), 32'h2);
    next_grant(g); chk("t2_alt0", 32'(g), 32'h1);
    next_grant(g); chk("t2_alt1b", 32'(g), 32'h2);
    m0_req = 0; m1_req = 0;
    repeat (4) cyc();
    mem_cack = 0; mem_ready = 0; mem_rdata = '0;

    // Port0 read: cack two cycles after issue, data three cycles later.
    m0_req = 1; m0_we = 0; m0_addr = 23'h000123;
    cyc();
    chk("t1_read_issued", 32'(mem_read), 32'd1);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_addr", 32'(mem_addr), 32'h000123);
    cyc();
    chk("t1_read_held", 32'(mem_read), 32'd1);
    mem_cack = 1; cyc(); mem_cack = 0;
    chk("t1_read_dropped", 32'(mem_read), 32'd0);
    cyc(); cyc();
    chk("t1_gnt_during", 32'(gnt), 32'h1);
    mem_ready = 1; mem_rdata = 32'hDEAD_BEEF; cyc();
    mem_ready = 0; mem_rdata = '0;
    chk("t1_done_not_yet", 32'(m0_done), 32'd0);
    cyc();
    chk("t1_done", 32'(m0_done), 32'd1);
    chk("t1_rdata", rdata, 32'hDEAD_BEEF);
    chk("t1_gnt_idle", 32'(gnt), 32'd0);
    m0_req = 0; cyc();
    chk("t1_done_once", 32'(m0_done), 32'd0);

    // Port1 write with cack one cycle after issue.
    m1_req = 1; m1_we = 1; m1_addr = 23'h004C00; m1_wdata = 16'hA5A5;
    cyc();
    chk("t3_write", 32'(mem_write), 32'd1);
    chk("t3_gnt", 32'(gnt), 32'h2);
    chk("t3_addr", 32'(mem_addr), 32'h004C00);
    chk("t3_wdata", 32'(mem_wdata), 32'h0000A5A5);
    mem_cack = 1; cyc(); mem_cack = 0;
    chk("t3_write_dropped", 32'(mem_write), 32'd0);
    cyc();
    chk("t3_done", 32'(m1_done), 32'd1);
    chk("t3_rdata_kept", rdata, 32'hDEAD_BEEF);
    m1_req = 0; m1_we = 0; cyc();

    // Busy controller blocks issue; top address passes through intact.
    mem_busy = 1; m0_req = 1; m0_we = 0; m0_addr = 23'h7FFFFF;
    repeat (10) cyc();
    chk("t4_blocked_read", 32'(mem_read), 32'd0);
    chk("t4_blocked_gnt", 32'(gnt), 32'd0);
    mem_busy = 0; cyc();
    chk("t4_issue", 32'(mem_read), 32'd1);
    chk("t4_addr", 32'(mem_addr), 32'h7FFFFF);
    mem_cack = 1; mem_ready = 1; mem_rdata = 32'h0BAD_F00D; cyc();
    mem_cack = 0; mem_ready = 0; mem_rdata = '0;
    cyc();
    chk("t4_done", 32'(m0_done), 32'd1);
    chk("t4_rdata", rdata, 32'h0BAD_F00D);
    m0_req = 0; cyc();

    // Timeout: command stays up TMO+1 cycles, then abort.
    m0_req = 1; m0_we = 0; m0_addr = 23'h000055;
    n = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (mem_read) n++;
      if (m0_done) begin seen = 1; break; end
    end
    chk("t5_done_seen", 32'(seen), 32'd1);
    chk("t5_cmd_cycles", 32'(n), 32'd17);
    chk("t5_rdata_zero", rdata, 32'd0);
    chk("t5_err_set", 32'(err), 32'd1);
    m0_req = 0;
    err_clr = 1; cyc(); err_clr = 0;
    chk("t5_err_cleared", 32'(err), 32'd0);

    // Reset while waiting for read data.
    m0_req = 1; m0_we = 0; m0_addr = 23'h000077;
    cyc();
    mem_cack = 1; cyc(); mem_cack = 0;
    cyc();
    chk("t6_gnt_before", 32'(gnt), 32'h1);
    rst_in = 0;
    #1;
    chk("t6_gnt_reset", 32'(gnt), 32'd0);
    chk("t6_read_reset", 32'(mem_read), 32'd0);
    chk("t6_done_reset", 32'(m0_done), 32'd0);
    model_reset();
    m0_req = 0; mem_ready = 1;
    cyc(); cyc();
    rst_in = 1;
    cyc(); cyc();
    chk("t6_no_done", 32'(m0_done), 32'd0);
    mem_ready = 0;
    m0_req = 1; m1_req = 1;
    next_grant(g); chk("t6_grant_after_reset", 32'(g), 32'h1);
    m0_req = 0; m1_req = 0; mem_cack = 1; mem_ready = 1;
    repeat (4) cyc();

    // Randomized traffic: responsive controller, then a slow one that provokes timeouts.
    rand_phase(1500, 35, 35);
    rand_phase(1500, 4, 8);
    rst_in = 1; m0_req = 0; m1_req = 0; mem_cack = 1; mem_ready = 1; mem_busy = 0; err_clr = 0;
    repeat (6) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
